// File: rtl/decoder_scan_seq.sv
// Break-before-make 3-to-8 decoder scanner: drives channels 0..7 for dwell+1
// cycles each with a one-cycle blank between channels, continuous or single sweep.
module decoder_scan_seq #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [DW-1:0] dwell,
    output logic          EN,
    output logic          A,
    output logic          B,
    output logic          C,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [2:0]    chan_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] dwell_q;
    logic          mode_q;
    logic          en_q;
    logic          busy_q;
    logic          done_q;

    logic [2:0]    chan_d;
    logic          last_d;

    // 3-bit increment wraps 7 -> 0 naturally for continuous mode
    assign chan_d = chan_q + 3'd1;
    assign last_d = (chan_q == 3'd7) && mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chan_q  <= 3'd0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    chan_q <= 3'd0;
                    // stop wins over a simultaneous start
                    if (start && !stop) begin
                        mode_q  <= mode;
                        dwell_q <= dwell;
                        cnt_q   <= dwell;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        chan_q  <= 3'd0;
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        en_q <= 1'b0;
                        if (last_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_BLANK;
                            chan_q  <= chan_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_BLANK: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        chan_q  <= 3'd0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_DRIVE;
                        cnt_q   <= dwell_q;
                        en_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    chan_q  <= 3'd0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    chan_q  <= 3'd0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign EN   = en_q;
    assign A    = chan_q[2];
    assign B    = chan_q[1];
    assign C    = chan_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule
